// File: rtl/conv_tap_pkg.sv
// Shared widths, FSM state type, stage-1 payload and saturation helper for the 3x3 tap accumulator.
package conv_tap_pkg;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned WGT_W     = 8;
  localparam int unsigned ACC_W     = 20;
  localparam int unsigned OUT_W     = 16;
  localparam int unsigned NUM_TAPS  = 9;
  localparam int unsigned TAP_LAST  = NUM_TAPS - 1;
  localparam int unsigned TAP_IDX_W = 4;
  localparam int unsigned PROD_W    = DATA_W + WGT_W;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } conv_state_e;

  // Registered multiplier result travelling from MUL to ACC.
  typedef struct packed {
    logic                     first;
    logic                     last;
    logic signed [PROD_W-1:0] prod;
  } mul_stage_t;

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [OUT_W-1:0] res;
    if (acc > SAT_MAX) begin
      res = SAT_MAX[OUT_W-1:0];
    end else if (acc < SAT_MIN) begin
      res = SAT_MIN[OUT_W-1:0];
    end else begin
      res = acc[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_tap_mac.sv
// Weight register file plus two-stage multiply/accumulate pipeline; the final sum is
// presented combinationally on the last-tap beat so the output register can capture it.
module conv_tap_mac
  import conv_tap_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wgt_we,
  input  logic [TAP_IDX_W-1:0]        wgt_addr,
  input  logic signed [WGT_W-1:0]     wgt_data,
  input  logic                        tap_en,
  input  logic                        tap_first,
  input  logic                        tap_last,
  input  logic [TAP_IDX_W-1:0]        tap_idx,
  input  logic signed [DATA_W-1:0]    pix_data,
  input  logic                        flush,
  output logic                        s1_valid,
  output logic                        result_valid_c,
  output logic signed [ACC_W-1:0]     result_c
);

  logic signed [WGT_W-1:0]  wgt [NUM_TAPS];
  logic signed [WGT_W-1:0]  wgt_sel;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_sum;
  mul_stage_t               s1;

  always_comb begin
    wgt_sel = '0;
    if (tap_idx <= TAP_IDX_W'(TAP_LAST)) begin
      wgt_sel = wgt[tap_idx];
    end
    prod_c = pix_data * wgt_sel;
  end

  // Weight writes land on the same edge that stage 1 reads, so a colliding tap sees the old weight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_TAPS); i++) begin
        wgt[i] <= '0;
      end
    end else if (wgt_we && (wgt_addr <= TAP_IDX_W'(TAP_LAST))) begin
      wgt[wgt_addr] <= wgt_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else begin
      s1_valid <= tap_en && !flush;
      if (tap_en) begin
        s1.first <= tap_first;
        s1.last  <= tap_last;
        s1.prod  <= prod_c;
      end
    end
  end

  always_comb begin
    acc_sum = s1.first ? ACC_W'(s1.prod) : acc + ACC_W'(s1.prod);
    result_valid_c = s1_valid && s1.last;
    result_c       = acc_sum;
  end

  // A discarded sequence zeroes the partial sum; tap 0 reloads it regardless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (flush) begin
      acc <= '0;
    end else if (s1_valid) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/conv3x3_tap_accumulator.sv
// 3x3 convolution tap accumulator: tap-order FSM, saturation and single-entry valid/ready output.
// Build option CONV_RELU_EN clamps negative saturated results to zero.
module conv3x3_tap_accumulator
  import conv_tap_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wgt_we,
  input  logic [TAP_IDX_W-1:0]  wgt_addr,
  input  logic [WGT_W-1:0]      wgt_data,
  input  logic                  tap_valid,
  input  logic [TAP_IDX_W-1:0]  tap_idx,
  input  logic [DATA_W-1:0]     pix_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_W-1:0]      out_data,
  output logic                  busy,
  output logic                  seq_err,
  output logic                  ovf_err
);

  conv_state_e              state;
  conv_state_e              state_next;
  logic [TAP_IDX_W-1:0]     exp_idx;
  logic [TAP_IDX_W-1:0]     exp_next;
  logic                     tap_accept;
  logic                     tap_first;
  logic                     tap_last;
  logic                     seq_bad;
  logic                     flush;
  logic                     s1_valid;
  logic                     result_valid_c;
  logic signed [ACC_W-1:0]  result_c;
  logic signed [OUT_W-1:0]  sat_c;
  logic [OUT_W-1:0]         out_res_c;
  logic                     out_load;
  logic                     out_drop;

  conv_tap_mac u_mac (
    .clk            (clk),
    .rst            (rst),
    .wgt_we         (wgt_we),
    .wgt_addr       (wgt_addr),
    .wgt_data       (wgt_data),
    .tap_en         (tap_accept),
    .tap_first      (tap_first),
    .tap_last       (tap_last),
    .tap_idx        (tap_idx),
    .pix_data       (pix_data),
    .flush          (flush),
    .s1_valid       (s1_valid),
    .result_valid_c (result_valid_c),
    .result_c       (result_c)
  );

  // Sequence checking: tap 0 always (re)starts, otherwise only the expected tap is accepted.
  always_comb begin
    state_next = state;
    exp_next   = exp_idx;
    tap_accept = 1'b0;
    tap_first  = 1'b0;
    tap_last   = 1'b0;
    seq_bad    = 1'b0;
    flush      = 1'b0;
    if (tap_valid) begin
      if (tap_idx == '0) begin
        tap_accept = 1'b1;
        tap_first  = 1'b1;
        state_next = ACCUM;
        exp_next   = TAP_IDX_W'(1);
        seq_bad    = (state == ACCUM);
      end else if ((state == ACCUM) && (tap_idx == exp_idx)) begin
        tap_accept = 1'b1;
        exp_next   = exp_idx + TAP_IDX_W'(1);
        if (tap_idx == TAP_IDX_W'(TAP_LAST)) begin
          tap_last   = 1'b1;
          state_next = IDLE;
        end
      end else begin
        seq_bad    = 1'b1;
        flush      = (state == ACCUM);
        state_next = IDLE;
      end
    end
  end

  always_comb begin
    sat_c = saturate(result_c);
`ifdef CONV_RELU_EN
    out_res_c = sat_c[OUT_W-1] ? '0 : sat_c;
`else
    out_res_c = sat_c;
`endif
    out_load = result_valid_c && (!out_valid || out_ready);
    out_drop = result_valid_c && out_valid && !out_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      exp_idx   <= '0;
      busy      <= 1'b0;
      seq_err   <= 1'b0;
      ovf_err   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state   <= state_next;
      exp_idx <= exp_next;
      busy    <= (state_next == ACCUM) || tap_accept;
      if (seq_bad) begin
        seq_err <= 1'b1;
      end
      if (out_drop) begin
        ovf_err <= 1'b1;
      end
      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= out_res_c;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/conv3x3_tap_accumulator.md
Name: conv3x3_tap_accumulator

Overview:
Downstream consumer of the 9-state filter tap sequencer. Each sequencer step presents one tap index (0..8) of a 3x3 kernel. The block multiplies the current window pixel by the matching weight from a 9-entry weight register file and accumulates the nine products. It emits one saturated convolution result per complete sequence over a valid/ready output port to the feature-map writer.

Parameters:
DATA_W, 8, signed pixel width
WGT_W, 8, signed weight width
ACC_W, 20, accumulator width (holds 9 full-scale products without overflow)
OUT_W, 16, signed output width after saturation
NUM_TAPS, 9, taps per kernel; last tap index = NUM_TAPS-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
wgt_we  in  1  weight write strobe
wgt_addr  in  4  weight index 0..8; writes to addr >8 ignored
wgt_data  in  WGT_W  signed weight value
tap_valid  in  1  tap_idx/pix_data valid this cycle; no backpressure to sequencer
tap_idx  in  4  kernel tap index from sequencer
pix_data  in  DATA_W  signed pixel for this tap
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_data  out  OUT_W  saturated signed convolution result
busy  out  1  accumulation in progress (ACCUM state or pipeline non-empty)
seq_err  out  1  sticky: out-of-order or out-of-range tap seen
ovf_err  out  1  sticky: result dropped because output register full

Behaviour:
- Reset, async: all outputs 0, accumulator 0, FSM to IDLE, weight file cleared to 0, pipeline valids 0.
- Weight file: 9 x WGT_W registers, written on the clk edge when wgt_we=1. A write and a read of the same tap in the same cycle uses the old weight.
- Stage 1, MUL: on tap_valid, register prod = pix_data * wgt[tap_idx], signed, DATA_W+WGT_W bits. Also register the tap index and a last flag.
- Stage 2, ACC: tap 0 loads acc = sign-extended prod. Taps 1..8 add to acc. Tap 8 also produces the result.
- Latency: tap 8 presented at cycle t -> out_valid=1 at t+2.
- FSM, tracking the expected tap (exp_idx):
  - IDLE: waits for tap_valid with tap_idx=0 -> ACCUM, exp_idx=1. Any other tap_valid -> seq_err=1, stay in IDLE.
  - ACCUM: tap_valid with tap_idx=exp_idx -> exp_idx+1. tap_idx=8 -> IDLE. Cycles with no tap_valid hold the state.
  - ACCUM with tap_idx=0: abort the partial sum, seq_err=1, restart with exp_idx=1.
  - ACCUM with any other mismatch, or tap_idx>8: seq_err=1, discard the partial sum, go to IDLE.
- Saturation: acc > 2^(OUT_W-1)-1 -> max positive; acc < -2^(OUT_W-1) -> min negative; otherwise truncate to OUT_W bits.
- Output register, single entry:
  - out_valid stays high until out_valid && out_ready.
  - A new result arriving in the same cycle as acceptance is loaded; there is no bubble.
  - A new result arriving while the register is full and not accepted is dropped, ovf_err=1, and the held result is unchanged.
- out_data is stable while out_valid=1 and out_ready=0.
- Sticky flags clear only on rst.
- Back-to-back sequences, tap 8 followed directly by tap 0, run at full rate: one result per 9 tap cycles.

Optional Feature:
CONV_RELU_EN
- Defined: after saturation, negative results are forced to 0 before loading the output register.
- Undefined: the signed saturated result passes unchanged.

Decomposition:
- Package conv_tap_pkg: NUM_TAPS, TAP_LAST=8, TAP_IDX_W=4, FSM state enum (IDLE, ACCUM), saturate function.
- Sub-module conv_tap_mac: weight file plus MUL/ACC pipeline, emitting result_valid/result.
- Top level holds the FSM, sequence checking, saturation/ReLU and the output handshake.

Test Plan:
1. All weights=1, pixels 1..9 on taps 0..8 with out_ready=1 -> out_data=45, out_valid one cycle, 2 cycles after tap 8.
2. All weights=127, pixels=127 -> acc=145161 -> out_data=32767. Weights=-128, pixels=127 -> out_data=-32768. With CONV_RELU_EN, the second case gives 0.
3. out_ready=0 through two full sequences (results 45, 90) -> out_data holds 45 and ovf_err=1. Then out_ready=1 -> 45 accepted, out_valid drops.
4. Tap sequence 0,1,2,5 -> seq_err=1, no result. A following clean 0..8 with weights=1 and pixels=2 -> out_data=18.
5. Taps 0..4 then rst asserted mid-sequence -> all outputs 0 immediately, weights 0. Reload weights=1 and run 0..8 with pixels=1 -> out_data=9.
6. wgt_we to addr 3 in the same cycle as tap 3 (old weight 1, new 5), pixels=1 -> first result 9, next sequence 13.
